// File: rtl/led_port_pkg.sv
// Shared register offsets, reset values and LED_MODE field positions for the LED port.
package led_port_pkg;

  typedef enum logic [1:0] {
    OFF_DATA = 2'd0,
    OFF_MODE = 2'd1,
    OFF_DIV  = 2'd2,
    OFF_RSVD = 2'd3
  } reg_off_e;

  localparam logic [7:0] DATA_RST = 8'h00;
  localparam logic [7:0] MODE_RST = 8'hF0;
  localparam logic [7:0] DIV_RST  = 8'h00;

  localparam int unsigned BLINK_BIT  = 0;
  localparam int unsigned BRIGHT_MSB = 7;
  localparam int unsigned BRIGHT_LSB = 4;

endpackage

// File: rtl/led_pwm_blink.sv
// PWM dimming counter and blink phase generator for the LED port.
module led_pwm_blink #(
  parameter int unsigned PRESCALE_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bright,
  input  logic       blink_en,
  input  logic [7:0] blink_div,
  input  logic       restart,
  input  logic       div_wr,
  output logic       pwm_on,
  output logic       phase
);
  import led_port_pkg::*;

  logic [3:0]            pwm_cnt;
  logic [PRESCALE_W-1:0] presc;
  logic [7:0]            tick_cnt;
  logic                  tick;

  assign tick   = &presc;
  assign pwm_on = (pwm_cnt <= bright);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  // Restart wins over everything so a freshly enabled blink starts a full visible half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      tick_cnt <= '0;
      phase    <= 1'b1;
    end else if (restart) begin
      presc    <= '0;
      tick_cnt <= '0;
      phase    <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      if (div_wr) begin
        tick_cnt <= '0;
      end else if (tick) begin
        if (tick_cnt == blink_div) begin
          tick_cnt <= '0;
          phase    <= ~phase;
        end else begin
          tick_cnt <= tick_cnt + 8'd1;
        end
      end
    end
  end

  logic unused_blink_en;
  assign unused_blink_en = blink_en;

endmodule

// File: rtl/led_mmio_port.sv
// Memory-mapped LED peripheral: bus decode, register file, read path and registered Led drive.
module led_mmio_port #(
  parameter int unsigned            ADDR_W     = 8,
  parameter logic [ADDR_W-1:0]      BASE_ADDR  = 8'hFC,
  parameter int unsigned            PRESCALE_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic              we,
  input  logic              re,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic [7:0]        Led
);
  import led_port_pkg::*;

  logic       hit;
  reg_off_e   off;
  logic [7:0] led_data;
  logic [3:0] bright;
  logic       blink_en;
  logic [7:0] blink_div;
  logic [7:0] mode_rd;
  logic [7:0] rd_mux;
  logic       wr_hit;
  logic       restart;
  logic       div_wr;
  logic       pwm_on;
  logic       phase;

  assign hit    = (addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign off    = reg_off_e'(addr[1:0]);
  assign wr_hit = we && hit;

  assign restart = wr_hit && (off == OFF_MODE) && wdata[BLINK_BIT] && !blink_en;
  assign div_wr  = wr_hit && (off == OFF_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_data  <= DATA_RST;
      blink_en  <= MODE_RST[BLINK_BIT];
      bright    <= MODE_RST[BRIGHT_MSB:BRIGHT_LSB];
      blink_div <= DIV_RST;
    end else if (wr_hit) begin
      unique case (off)
        OFF_DATA: led_data <= wdata;
        OFF_MODE: begin
          blink_en <= wdata[BLINK_BIT];
          bright   <= wdata[BRIGHT_MSB:BRIGHT_LSB];
        end
        OFF_DIV:  blink_div <= wdata;
        OFF_RSVD: ;
      endcase
    end
  end

  always_comb begin
    mode_rd                        = '0;
    mode_rd[BRIGHT_MSB:BRIGHT_LSB] = bright;
    mode_rd[BLINK_BIT]             = blink_en;
  end

  always_comb begin
    rd_mux = '0;
    unique case (off)
      OFF_DATA: rd_mux = led_data;
      OFF_MODE: rd_mux = mode_rd;
      OFF_DIV:  rd_mux = blink_div;
      OFF_RSVD: rd_mux = '0;
    endcase
  end

  // Read mux sees pre-edge register contents, so a same-cycle write is returned as the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re && hit;
      if (re && hit) begin
        rdata <= rd_mux;
      end
    end
  end

  led_pwm_blink #(
    .PRESCALE_W(PRESCALE_W)
  ) u_pwm_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .bright   (bright),
    .blink_en (blink_en),
    .blink_div(blink_div),
    .restart  (restart),
    .div_wr   (div_wr),
    .pwm_on   (pwm_on),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Led <= '0;
    end else begin
      Led <= led_data & {8{pwm_on}} & {8{~blink_en | phase}};
    end
  end

endmodule

// File: doc/led_mmio_port.md
# led_mmio_port

Memory-mapped LED output peripheral sitting between the processor's data-memory bus and the 8 board `Led` pins of the Atlys top level. The processor writes pattern, brightness and blink settings through a small register window. The block drives `Led` with a registered, PWM-dimmed and optionally blinking version of the pattern. Registers are readable so software can do read-modify-write.

## Interface

**Parameters**
- `ADDR_W`, 8: bus address width.
- `BASE_ADDR`, 8'hFC: window base. Bits [1:0] must be 0; the window is 4 words.
- `PRESCALE_W`, 20: prescaler width. One blink tick every 2^PRESCALE_W clocks. Benches use 4.

**Ports**
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `addr`, in, ADDR_W: bus address.
- `wdata`, in, 8: write data.
- `we`, in, 1: write strobe, single-cycle, sampled on the rising edge of `clk`.
- `re`, in, 1: read strobe, single-cycle.
- `rdata`, out, 8: read data, valid while `rvalid` is high.
- `rvalid`, out, 1: one-cycle pulse, one clock after an in-window `re`.
- `Led`, out, 8: board LED drive, registered.

## Operation

**Address decode**
- A transaction hits when `addr[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]`.
- Offset is `addr[1:0]`.
- Out-of-window `we` is ignored.
- Out-of-window `re` produces no `rvalid`, so other slaves own that address.

**Registers**
- Offset 0, LED_DATA, R/W. Reset 8'h00.
- Offset 1, LED_MODE, R/W. Reset 8'hF0.
  - bit0 `blink_en`.
  - bits[3:1] read 0; writes to them are ignored.
  - bits[7:4] `bright`.
- Offset 2, BLINK_DIV, R/W. Reset 8'h00. Blink phase toggles every BLINK_DIV+1 ticks.
- Offset 3: reserved. Reads return 8'h00 with `rvalid`; writes are ignored.

**PWM**
- 4-bit free-running `pwm_cnt` increments every clock and wraps 15→0.
- `pwm_on = (pwm_cnt <= bright)`, giving a duty of (bright+1)/16.
- `bright` = 15 means constantly on.

**Blink**
- Prescaler counts 0..2^PRESCALE_W−1 and wraps.
- A `tick` is asserted on the wrap cycle.
- `tick_cnt` counts ticks. When `tick_cnt == BLINK_DIV` on a tick, `phase` toggles and `tick_cnt` returns to 0.
- Writing LED_MODE with `blink_en` 0→1 forces `phase` = 1 and clears `tick_cnt` and the prescaler, so the pattern is visible immediately.
- Writing BLINK_DIV clears `tick_cnt`.

**Output**
- Next `Led` = LED_DATA & {8{pwm_on}} & {8{~blink_en | phase}}.

**Simultaneous events**
- `we` and `re` to the same offset in one cycle: the read returns the pre-write value, and the write takes effect.
- `we` and `re` to different offsets are both serviced.
- `re` every cycle yields back-to-back `rvalid` pulses.

**Reset**
- Asynchronous and immediate, including mid-blink or mid-read.
- All registers return to their reset values.
- `pwm_cnt`, prescaler and `tick_cnt` reset to 0; `phase` resets to 1.
- `rdata` = 0, `rvalid` = 0, `Led` = 0.
- A read in flight at reset is dropped, with no `rvalid`.

## Timing

- Write sampled at edge k: the register holds the new value after edge k, and `Led` reflects it after edge k+1. Write-to-pin latency is 2 edges.
- Read sampled at edge k: `rdata` and `rvalid` are valid after edge k and drop after edge k+1 unless another read is issued.
- `rdata` holds its last value when `rvalid` = 0.
- Blink half-period is (BLINK_DIV+1)·2^PRESCALE_W clocks. The PWM period is 16 clocks.
- No stalls: the block accepts one transaction per clock, always.

## Structure

- **Package `led_port_pkg`**:
  - offsets `OFF_DATA`, `OFF_MODE`, `OFF_DIV`;
  - reset constants `MODE_RST` = 8'hF0, `DATA_RST`, `DIV_RST`;
  - LED_MODE field positions `BLINK_BIT` = 0 and `BRIGHT_MSB/LSB` = 7/4.
- **Sub-module `led_pwm_blink`**:
  - contains `pwm_cnt`, prescaler, `tick_cnt` and `phase`;
  - inputs: `bright`, `blink_en`, `blink_div`, `restart`;
  - outputs: `pwm_on`, `phase`.
- **Top `led_mmio_port`**: bus decode, register file, read path and the `Led` output register.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-stream → `Led` = 0, `rvalid` = 0. After release, reading offset 1 returns 8'hF0 and offset 0 returns 8'h00.
- **Write/readback:** write 8'hA5 to offset 0 → `Led` = 8'hA5 two edges later. A read returns 8'hA5 one cycle after `re`. Write 8'hFF to offset 1 → reads back 8'hF1.
- **PWM:** set LED_DATA = 8'hFF and bright = 3 → `Led` = 8'hFF for exactly 4 of every 16 clocks. With bright = 15, `Led` is always on.
- **Blink:** `PRESCALE_W` = 4, BLINK_DIV = 1, blink enabled → `Led` is on for 32 clocks, then off for 32 clocks, repeating. Re-enabling blink mid-off-phase turns the pattern on at the next output edge.
- **Same-cycle read/write:** `we` = 8'h3C and `re` to offset 0 in one cycle with old value 8'hA5 → `rdata` = 8'hA5, and the next read returns 8'h3C.
- **Decode:** access `addr` = 8'hF8 → no `rvalid`, registers unchanged. A read of offset 3 → `rvalid` with `rdata` = 8'h00.
